// File: rtl/hot_query_pkg.sv
// Shared state encoding and counter-width helpers for the hot-tracker query initiator.
package hot_query_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        COLLECT = 2'd2
    } state_t;

    localparam int unsigned DEF_QUERY_INTERVAL = 2000;
    localparam int unsigned DEF_NUM_ENTRY      = 25;
    localparam int unsigned DEF_TIMEOUT        = 1024;

    localparam int unsigned ACC_CNT_W  = $clog2(DEF_QUERY_INTERVAL + 1);
    localparam int unsigned RX_CNT_W   = $clog2(DEF_NUM_ENTRY + 1);
    localparam int unsigned IDLE_CNT_W = $clog2(DEF_TIMEOUT);

    // Width able to hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mig_addr_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is visible whenever the FIFO is non-empty.
module mig_addr_fifo #(
    parameter int unsigned DATA_W = 33,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_push_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              w_push_en;
    logic              w_pop_en;

    // Extra pointer MSB tells a full FIFO apart from an empty one.
    assign o_level    = r_wptr - r_rptr;
    assign o_empty    = (r_wptr == r_rptr);
    assign o_full     = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_pop_en   = i_pop & ~o_empty;
    assign w_push_en  = i_push & (~o_full | w_pop_en);
    assign o_pop_data = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_en) r_wptr <= r_wptr + 1'b1;
            if (w_pop_en)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_en) r_mem[r_wptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/hot_query_initiator.sv
// Issues periodic or forced queries to the hot tracker and buffers the returned
// migration addresses in a FIFO drained by the host side.
module hot_query_initiator
    import hot_query_pkg::*;
#(
    parameter int unsigned ADDR_SIZE      = 33,
    parameter int unsigned NUM_ENTRY      = 25,
    parameter int unsigned QUERY_INTERVAL = 2000,
    parameter int unsigned FIFO_DEPTH     = 32,
    parameter int unsigned TIMEOUT        = 1024
) (
    input  logic                          afu_clk,
    input  logic                          afu_rst,
    input  logic                          ar_valid,
    input  logic                          ar_ready,
    input  logic                          query_force,
    output logic                          query_en,
    input  logic                          query_ready,
    input  logic                          mig_addr_en,
    input  logic [ADDR_SIZE-1:0]          mig_addr,
    output logic                          mig_addr_ready,
    output logic                          pop_valid,
    output logic [ADDR_SIZE-1:0]          pop_data,
    input  logic                          pop_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          query_done,
    output logic [31:0]                   query_cnt,
    output logic [15:0]                   drop_cnt
);
    localparam int unsigned ACC_W  = cnt_w(QUERY_INTERVAL + 1);
    localparam int unsigned RX_W   = cnt_w(NUM_ENTRY + 1);
    localparam int unsigned IDLE_W = cnt_w(TIMEOUT);

    localparam logic [ACC_W-1:0]  ACC_MAX   = ACC_W'(QUERY_INTERVAL);
    localparam logic [RX_W-1:0]   RX_LAST   = RX_W'(NUM_ENTRY - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_d;
    logic [ACC_W-1:0]    r_acc_cnt;
    logic [ACC_W-1:0]    w_acc_cnt_d;
    logic                r_force_pend;
    logic                w_force_pend_d;
    logic [RX_W-1:0]     r_rx_cnt;
    logic [RX_W-1:0]     w_rx_cnt_d;
    logic [IDLE_W-1:0]   r_idle_cnt;
    logic [IDLE_W-1:0]   w_idle_cnt_d;
    logic                w_done_d;

    logic                r_query_en;
    logic                r_mig_ready;
    logic                r_query_done;
    logic [31:0]         r_query_cnt;
    logic [15:0]         r_drop_cnt;

    logic                w_hs;
    logic                w_trigger;
    logic                w_beat;
    logic                w_full;
    logic                w_empty;
    logic                w_pop_hs;
    logic                w_drop;

    assign w_hs      = ar_valid & ar_ready;
    assign w_trigger = (r_acc_cnt == ACC_MAX) | r_force_pend;
    assign w_beat    = (r_state == COLLECT) & mig_addr_en;
    assign w_pop_hs  = pop_ready & ~w_empty;
    // A beat on a full FIFO survives only if a pop frees a slot in the same cycle.
    assign w_drop    = w_beat & w_full & ~w_pop_hs;

    always_comb begin
        w_state_d      = r_state;
        w_acc_cnt_d    = r_acc_cnt;
        w_force_pend_d = r_force_pend;
        w_rx_cnt_d     = r_rx_cnt;
        w_idle_cnt_d   = r_idle_cnt;
        w_done_d       = 1'b0;

        if (w_hs && (r_acc_cnt != ACC_MAX)) w_acc_cnt_d = r_acc_cnt + 1'b1;

        unique case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_state_d      = REQ;
                    w_acc_cnt_d    = ACC_W'(w_hs);
                    w_force_pend_d = 1'b0;
                end
            end
            REQ: begin
                if (r_query_en && query_ready) begin
                    w_state_d    = COLLECT;
                    w_rx_cnt_d   = '0;
                    w_idle_cnt_d = '0;
                end
            end
            COLLECT: begin
                if (mig_addr_en) begin
                    w_rx_cnt_d   = r_rx_cnt + 1'b1;
                    w_idle_cnt_d = '0;
                    if (r_rx_cnt == RX_LAST) begin
                        w_state_d = IDLE;
                        w_done_d  = 1'b1;
                    end
                end else if (r_idle_cnt == IDLE_LAST) begin
                    w_state_d = IDLE;
                    w_done_d  = 1'b1;
                end else begin
                    w_idle_cnt_d = r_idle_cnt + 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase

        // A new software request is never lost, even on the cycle a query launches.
        if (query_force) w_force_pend_d = 1'b1;
    end

    always_ff @(posedge afu_clk or posedge afu_rst) begin
        if (afu_rst) begin
            r_state      <= IDLE;
            r_acc_cnt    <= '0;
            r_force_pend <= 1'b0;
            r_rx_cnt     <= '0;
            r_idle_cnt   <= '0;
            r_query_en   <= 1'b0;
            r_mig_ready  <= 1'b0;
            r_query_done <= 1'b0;
            r_query_cnt  <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_state      <= w_state_d;
            r_acc_cnt    <= w_acc_cnt_d;
            r_force_pend <= w_force_pend_d;
            r_rx_cnt     <= w_rx_cnt_d;
            r_idle_cnt   <= w_idle_cnt_d;
            r_query_en   <= (w_state_d == REQ);
            r_mig_ready  <= (w_state_d == COLLECT);
            r_query_done <= w_done_d;
            if (w_done_d) r_query_cnt <= r_query_cnt + 1'b1;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    mig_addr_fifo #(
        .DATA_W (ADDR_SIZE),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (afu_clk),
        .i_rst       (afu_rst),
        .i_push      (w_beat),
        .i_push_data (mig_addr),
        .i_pop       (pop_ready),
        .o_pop_data  (pop_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fifo_level)
    );

    assign query_en       = r_query_en;
    assign mig_addr_ready = r_mig_ready;
    assign query_done     = r_query_done;
    assign query_cnt      = r_query_cnt;
    assign drop_cnt       = r_drop_cnt;
    assign pop_valid      = ~w_empty;

endmodule

// File: tb/tb_hot_query_initiator.sv
// Directed bench: two instances (FIFO depth 32 and 16) share one stimulus stream.
module tb_hot_query_initiator;

    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ar_valid = 1'b0;
    logic        ar_ready = 1'b0;
    logic        query_force = 1'b0;
    logic        query_ready = 1'b0;
    logic        mig_addr_en = 1'b0;
    logic [32:0] mig_addr = '0;
    logic        pop_ready = 1'b0;

    logic        a_query_en, a_mig_ready, a_pop_valid, a_query_done;
    logic [32:0] a_pop_data;
    logic [5:0]  a_level;
    logic [31:0] a_query_cnt;
    logic [15:0] a_drop_cnt;

    logic        b_query_en, b_mig_ready, b_pop_valid, b_query_done;
    logic [32:0] b_pop_data;
    logic [4:0]  b_level;
    logic [31:0] b_query_cnt;
    logic [15:0] b_drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hot_query_initiator #(
        .ADDR_SIZE(33), .NUM_ENTRY(25), .QUERY_INTERVAL(2000), .FIFO_DEPTH(32), .TIMEOUT(TO)
    ) u_dut_a (
        .afu_clk(clk), .afu_rst(rst), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .query_force(query_force), .query_en(a_query_en), .query_ready(query_ready),
        .mig_addr_en(mig_addr_en), .mig_addr(mig_addr), .mig_addr_ready(a_mig_ready),
        .pop_valid(a_pop_valid), .pop_data(a_pop_data), .pop_ready(pop_ready),
        .fifo_level(a_level), .query_done(a_query_done), .query_cnt(a_query_cnt),
        .drop_cnt(a_drop_cnt)
    );

    hot_query_initiator #(
        .ADDR_SIZE(33), .NUM_ENTRY(25), .QUERY_INTERVAL(2000), .FIFO_DEPTH(16), .TIMEOUT(TO)
    ) u_dut_b (
        .afu_clk(clk), .afu_rst(rst), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .query_force(query_force), .query_en(b_query_en), .query_ready(query_ready),
        .mig_addr_en(mig_addr_en), .mig_addr(mig_addr), .mig_addr_ready(b_mig_ready),
        .pop_valid(b_pop_valid), .pop_data(b_pop_data), .pop_ready(pop_ready),
        .fifo_level(b_level), .query_done(b_query_done), .query_cnt(b_query_cnt),
        .drop_cnt(b_drop_cnt)
    );

    typedef struct {
        logic [32:0] addr;
        logic        pop;
        logic [32:0] head_b;
        logic        done;
        logic        rdy;
        int          lvl_a;
        int          lvl_b;
        int          drop_b;
    } vec_t;

    vec_t tbl [2][25];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_qen(input logic exp);
        chk("query_en_a", 64'(a_query_en), 64'(exp));
        chk("query_en_b", 64'(b_query_en), 64'(exp));
    endtask

    task automatic chk_ctl(input logic done, input logic rdy);
        chk("query_done_a", 64'(a_query_done), 64'(done));
        chk("query_done_b", 64'(b_query_done), 64'(done));
        chk("mig_ready_a", 64'(a_mig_ready), 64'(rdy));
        chk("mig_ready_b", 64'(b_mig_ready), 64'(rdy));
    endtask

    task automatic chk_fifo(input int lvl_a, input int lvl_b, input int drop_b);
        chk("level_a", 64'(a_level), 64'(lvl_a));
        chk("level_b", 64'(b_level), 64'(lvl_b));
        chk("pop_valid_a", 64'(a_pop_valid), 64'(lvl_a != 0));
        chk("pop_valid_b", 64'(b_pop_valid), 64'(lvl_b != 0));
        chk("drop_a", 64'(a_drop_cnt), 64'd0);
        chk("drop_b", 64'(b_drop_cnt), 64'(drop_b));
    endtask

    task automatic chk_qcnt(input int exp);
        chk("query_cnt_a", 64'(a_query_cnt), 64'(exp));
        chk("query_cnt_b", 64'(b_query_cnt), 64'(exp));
    endtask

    task automatic handshakes(input int n);
        ar_valid = 1'b1;
        ar_ready = 1'b1;
        step(n);
        ar_valid = 1'b0;
        ar_ready = 1'b0;
    endtask

    task automatic pulse_force();
        query_force = 1'b1;
        step();
        query_force = 1'b0;
    endtask

    task automatic accept();
        query_ready = 1'b1;
        step();
        query_ready = 1'b0;
        chk_qen(1'b0);
        chk_ctl(1'b0, 1'b1);
    endtask

    task automatic apply_tbl(input int k);
        for (int i = 0; i < 25; i++) begin
            mig_addr_en = 1'b1;
            mig_addr    = tbl[k][i].addr;
            pop_ready   = tbl[k][i].pop;
            if (tbl[k][i].pop) chk("head_b", 64'(b_pop_data), 64'(tbl[k][i].head_b));
            step();
            chk_ctl(tbl[k][i].done, tbl[k][i].rdy);
            chk_fifo(tbl[k][i].lvl_a, tbl[k][i].lvl_b, tbl[k][i].drop_b);
        end
        mig_addr_en = 1'b0;
        pop_ready   = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 25; i++) begin
            tbl[0][i].addr   = 33'h1000 + 33'(i);
            tbl[0][i].pop    = 1'b0;
            tbl[0][i].head_b = '0;
            tbl[0][i].done   = (i == 24);
            tbl[0][i].rdy    = (i != 24);
            tbl[0][i].lvl_a  = i + 1;
            tbl[0][i].lvl_b  = (i + 1 > 16) ? 16 : i + 1;
            tbl[0][i].drop_b = (i > 15) ? i - 15 : 0;

            tbl[1][i].addr   = 33'h3000 + 33'(i);
            tbl[1][i].pop    = (i >= 16);
            tbl[1][i].head_b = 33'h3000 + 33'((i >= 16) ? i - 16 : 0);
            tbl[1][i].done   = (i == 24);
            tbl[1][i].rdy    = (i != 24);
            tbl[1][i].lvl_a  = (i + 1 > 16) ? 16 : i + 1;
            tbl[1][i].lvl_b  = (i + 1 > 16) ? 16 : i + 1;
            tbl[1][i].drop_b = 9;
        end

        // Reset state
        step(2);
        chk_qen(1'b0);
        chk_ctl(1'b0, 1'b0);
        chk_fifo(0, 0, 0);
        chk_qcnt(0);
        chk("pop_data_a_rst", 64'(a_pop_data), 64'd0);
        rst = 1'b0;
        step();

        // Periodic trigger after 2000 handshakes, then a 5-cycle stall before acceptance
        handshakes(1999);
        chk_qen(1'b0);
        handshakes(1);
        chk_qen(1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk_qen(1'b1);
            if (i < 4) step();
        end
        accept();

        // 25 back-to-back beats, no pops: depth-16 copy drops 9
        apply_tbl(0);
        step();
        chk_ctl(1'b0, 1'b0);
        chk_qcnt(1);
        pop_ready = 1'b1;
        for (int k = 0; k < 25; k++) begin
            chk("pop_data_a", 64'(a_pop_data), 64'h1000 + 64'(k));
            if (k < 16) chk("pop_data_b", 64'(b_pop_data), 64'h1000 + 64'(k));
            step();
        end
        pop_ready = 1'b0;
        chk_fifo(0, 0, 9);

        // Forced query; accesses reach 2000 during REQ, another force during COLLECT
        pulse_force();
        chk_qen(1'b0);
        step();
        chk_qen(1'b1);
        handshakes(2000);
        chk_qen(1'b1);
        accept();
        pulse_force();
        apply_tbl(1);
        chk_qcnt(2);
        step();
        chk_qen(1'b1);
        chk_ctl(1'b0, 1'b0);
        pop_ready = 1'b1;
        step(17);
        pop_ready = 1'b0;
        chk_qen(1'b1);
        chk_fifo(0, 0, 9);

        // Three beats only, then abandon after TO idle cycles
        accept();
        for (int i = 0; i < 3; i++) begin
            mig_addr_en = 1'b1;
            mig_addr    = 33'h4000 + 33'(i);
            step();
        end
        mig_addr_en = 1'b0;
        step(TO - 1);
        chk_ctl(1'b0, 1'b1);
        step();
        chk_ctl(1'b1, 1'b0);
        chk_fifo(3, 3, 9);
        chk_qcnt(3);
        step();
        chk_qen(1'b0);
        pop_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("pop_data_a_to", 64'(a_pop_data), 64'h4000 + 64'(k));
            step();
        end
        pop_ready = 1'b0;

        // Access counter restarted from 0 at the last launch
        handshakes(1999);
        step(2);
        chk_qen(1'b0);
        handshakes(1);
        chk_qen(1'b0);
        step();
        chk_qen(1'b1);
        accept();

        // Reset mid-COLLECT with 10 entries queued
        for (int i = 0; i < 10; i++) begin
            mig_addr_en = 1'b1;
            mig_addr    = 33'h5000 + 33'(i);
            step();
        end
        mig_addr_en = 1'b0;
        chk_fifo(10, 10, 9);
        rst = 1'b1;
        #1;
        chk_ctl(1'b0, 1'b0);
        chk_qen(1'b0);
        chk_fifo(0, 0, 0);
        chk_qcnt(0);
        step();
        rst = 1'b0;
        step();

        // Next query after reset behaves normally
        pulse_force();
        chk_qen(1'b0);
        step();
        chk_qen(1'b1);
        accept();
        for (int i = 0; i < 2; i++) begin
            mig_addr_en = 1'b1;
            mig_addr    = 33'h6000 + 33'(i);
            step();
        end
        mig_addr_en = 1'b0;
        step(TO);
        chk_ctl(1'b1, 1'b0);
        chk_fifo(2, 2, 0);
        chk_qcnt(1);
        chk("pop_data_a_post", 64'(a_pop_data), 64'h6000);
        chk("pop_data_b_post", 64'(b_pop_data), 64'h6000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
